// File: rtl/switch_box_config_loader.sv
// Config loader for one universal_switch_box: assembles CW-bit words into a shadow
// register and commits it to the live config in a single edge. Optional macro: CFG_PARITY_EN.
module switch_box_config_loader #(
    parameter int WS = 7,
    parameter int WD = 6,
    parameter int WG = 3,
    parameter int CW = 8,
    localparam int CFG_BITS = WS*6 + (WD/2)*6,
    localparam int NWORDS   = (CFG_BITS + CW - 1) / CW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CW-1:0]       cfg_data,
    input  logic                cfg_parity,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CFG_BITS-1:0] c,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          o_dbg_state
);

    localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_c;
    logic                r_busy;
    logic                r_done;
    logic [CFG_BITS-1:0] w_shadow_wr;
    logic                w_xfer;
    logic                w_last;
    logic                w_par_ok;
    logic                w_unused;

    // Handshake: a word moves on a rising edge with cfg_valid && cfg_ready; cfg_ready is
    // high only in LOAD, and an abort in the same cycle drops the word.
    assign cfg_ready = (r_state == ST_LOAD);
    assign w_xfer    = cfg_valid && cfg_ready && !abort;
    assign w_last    = (r_word_cnt == CNT_W'(NWORDS - 1));

    // Bits of the last word that land at or above CFG_BITS have no home and fall away.
    always_comb begin
        w_shadow_wr = r_shadow;
        for (int i = 0; i < CFG_BITS; i++) begin
            if ((i / CW) == int'(r_word_cnt)) begin
                w_shadow_wr[i] = cfg_data[i % CW];
            end
        end
    end

`ifdef CFG_PARITY_EN
    logic r_err;

    assign w_par_ok = ^{cfg_data, cfg_parity};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_err <= 1'b0;
        end else if (w_xfer && !w_par_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_par_ok = 1'b1;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_shadow   <= '0;
            r_c        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b1;
                        r_word_cnt <= '0;
                        r_shadow   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_xfer && !w_par_ok) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_xfer) begin
                        r_shadow   <= w_shadow_wr;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    // The only place the live config changes outside reset.
                    r_c     <= r_shadow;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign c           = r_c;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

    // WG carries no config bits; cfg_parity is unused when parity checking is absent.
    assign w_unused = ^{cfg_parity, (WG >= 0)};

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Bench for switch_box_config_loader: vector table, hand-written reset/abort sequences and
// randomized loads against a packing model. Parity cases build only with CFG_PARITY_EN.
module tb_switch_box_config_loader;

    localparam int WS       = 7;
    localparam int WD       = 6;
    localparam int WG       = 3;
    localparam int CW       = 8;
    localparam int CFG_BITS = WS*6 + (WD/2)*6;
    localparam int NWORDS   = (CFG_BITS + CW - 1) / CW;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [CW-1:0]       cfg_data = '0;
    logic                cfg_parity = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CFG_BITS-1:0] c;
    logic                busy;
    logic                done;
    logic                err;
    logic [1:0]          dbg_state;

    switch_box_config_loader #(.WS(WS), .WD(WD), .WG(WG), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_parity(cfg_parity), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .c(c), .busy(busy), .done(done), .err(err),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_atomic_viol = 0;
    logic [CFG_BITS-1:0] exp_q[$];
    logic [CFG_BITS-1:0] model_c = '0;
    logic                model_err = 1'b0;
    logic [CFG_BITS-1:0] prev_c = '0;
    logic [CW-1:0]       words[NWORDS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: word k occupies bits [k*CW +: CW]; bits past CFG_BITS are discarded.
    function automatic logic [CFG_BITS-1:0] pack_words();
        logic [NWORDS*CW-1:0] acc;
        acc = '0;
        for (int k = 0; k < NWORDS; k++) acc[k*CW +: CW] = words[k];
        return acc[CFG_BITS-1:0];
    endfunction

    // Monitor at the falling edge: transfers, commit values, and c moving without done.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_valid && cfg_ready && !abort) n_xfer++;
            if (c !== prev_c && !done) n_atomic_viol++;
            if (done) begin
                if (exp_q.size() == 0) check("unexpected_done", done, 1'b0);
                else check("commit_value", c, exp_q.pop_front());
            end
        end
        prev_c = c;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: valid always high, 1: every other cycle, 2: random gaps.
    // abort_at: word index at which abort is raised (-1 none).
    // flip_at: word index sent with even parity (-1 none).
    task automatic do_load(input int mode, input int abort_at, input int flip_at);
        int sent;
        int cyc;
        int x0;
        logic v;
        logic x;
        logic bad_en;
        logic [CFG_BITS-1:0] old_c;
        logic [CFG_BITS-1:0] new_c;
`ifdef CFG_PARITY_EN
        bad_en = 1'b1;
`else
        bad_en = 1'b0;
`endif
        sent  = 0;
        cyc   = 0;
        old_c = model_c;
        new_c = pack_words();
        if (abort_at < 0 && !(bad_en && flip_at >= 0)) exp_q.push_back(new_c);
        start = 1'b1;
        step();
        start = 1'b0;
        x0 = n_xfer;
        model_err = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_ready", cfg_ready, 1'b1);
        check("start_err", err, 1'b0);
        while (sent < NWORDS && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            cfg_valid  = v;
            cfg_data   = words[sent];
            cfg_parity = (~^words[sent]) ^ (sent == flip_at);
            abort      = v && (sent == abort_at);
            x          = v && cfg_ready;
            step();
            cyc++;
            if (abort) begin
                abort     = 1'b0;
                cfg_valid = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_ready", cfg_ready, 1'b0);
                check("abort_c_kept", c, old_c);
                check("abort_xfers", n_xfer - x0, abort_at);
                return;
            end
            if (x && bad_en && sent == flip_at) begin
                cfg_valid = 1'b0;
                model_err = 1'b1;
                check("parity_err", err, model_err);
                check("parity_busy", busy, 1'b0);
                check("parity_ready", cfg_ready, 1'b0);
                check("parity_c_kept", c, old_c);
                check("parity_xfers", n_xfer - x0, flip_at + 1);
                step();
                check("parity_err_sticky", err, 1'b1);
                check("parity_no_done", done, 1'b0);
                return;
            end
            if (x) sent++;
        end
        cfg_valid = 1'b0;
        check("load_completed", sent, NWORDS);
        if (mode == 0) check("latency_xfer_cycles", cyc, NWORDS);
        check("commit_busy", busy, 1'b1);
        check("commit_ready", cfg_ready, 1'b0);
        check("commit_c_held", c, old_c);
        step();
        model_c = new_c;
        check("done_pulse", done, 1'b1);
        check("done_busy_low", busy, 1'b0);
        check("done_c_new", c, model_c);
        check("load_xfers", n_xfer - x0, NWORDS);
        check("load_err", err, model_err);
        step();
        check("done_single", done, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          start;
        logic          valid;
        logic [CW-1:0] data;
        logic          abort;
        logic          exp_busy;
        logic          exp_ready;
        logic          exp_done;
        logic          commit;
    } vec_t;

    vec_t vecs[NWORDS + 4];

    initial begin
        int x0;
        logic [CFG_BITS-1:0] exp_c;
        logic [CFG_BITS-1:0] golden;

        // idle row: data, valid and abort must all be ignored
        vecs[0] = '{start: 1'b0, valid: 1'b1, data: 8'hAA, abort: 1'b1,
                    exp_busy: 1'b0, exp_ready: 1'b0, exp_done: 1'b0, commit: 1'b0};
        vecs[1] = '{start: 1'b1, valid: 1'b0, data: 8'h00, abort: 1'b0,
                    exp_busy: 1'b1, exp_ready: 1'b1, exp_done: 1'b0, commit: 1'b0};
        for (int k = 0; k < NWORDS; k++) begin
            vecs[2+k].start     = 1'b0;
            vecs[2+k].valid     = 1'b1;
            vecs[2+k].data      = CW'(k + 1);
            vecs[2+k].abort     = 1'b0;
            vecs[2+k].exp_busy  = 1'b1;
            vecs[2+k].exp_ready = (k < NWORDS - 1);
            vecs[2+k].exp_done  = 1'b0;
            vecs[2+k].commit    = 1'b0;
        end
        vecs[NWORDS+2] = '{start: 1'b0, valid: 1'b0, data: 8'h00, abort: 1'b0,
                           exp_busy: 1'b0, exp_ready: 1'b0, exp_done: 1'b1, commit: 1'b1};
        vecs[NWORDS+3] = '{start: 1'b0, valid: 1'b0, data: 8'h00, abort: 1'b0,
                           exp_busy: 1'b0, exp_ready: 1'b0, exp_done: 1'b0, commit: 1'b0};

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        #1;
        check("rst_c", c, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        #10 rst = 1'b0;
        step();

        // ---------------- back-to-back load from the table ----------------
        for (int k = 0; k < NWORDS; k++) words[k] = CW'(k + 1);
        exp_c = model_c;
        exp_q.push_back(pack_words());
        x0 = n_xfer;
        for (int i = 0; i < NWORDS + 4; i++) begin
            start      = vecs[i].start;
            cfg_valid  = vecs[i].valid;
            cfg_data   = vecs[i].data;
            cfg_parity = ~^vecs[i].data;
            abort      = vecs[i].abort;
            step();
            if (vecs[i].commit) exp_c = pack_words();
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_done", i), done, vecs[i].exp_done);
            check($sformatf("vec%0d_c", i), c, exp_c);
        end
        model_c = exp_c;
        golden  = 60'h807060504030201;
        check("table_xfers", n_xfer - x0, NWORDS);
        check("table_c_golden", c, golden);

        // ---------------- asynchronous reset mid-cycle ----------------
        #2 rst = 1'b1;
        #1;
        check("async_rst_c", c, '0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", cfg_ready, 1'b0);
        check("async_rst_done", done, 1'b0);
        #3 rst = 1'b0;
        model_c = '0;
        step();

        // ---------------- gapped valid, then abort after 3 words ----------------
        do_load(1, -1, -1);
        check("gapped_c_golden", c, golden);
        for (int k = 0; k < NWORDS; k++) words[k] = CW'($urandom_range(0, 255));
        do_load(0, 3, -1);
        check("abort_c_golden", c, golden);

        // ---------------- start during LOAD, reset after 4 words ----------------
        for (int k = 0; k < NWORDS; k++) words[k] = CW'(k + 1);
        start = 1'b1;
        step();
        cfg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cfg_data   = words[k];
            cfg_parity = ~^words[k];
            step();
        end
        check("mid_load_busy", busy, 1'b1);
        check("mid_load_c_kept", c, golden);
        #2 rst = 1'b1;
        #1;
        check("mid_load_rst_c", c, '0);
        check("mid_load_rst_busy", busy, 1'b0);
        start     = 1'b0;
        cfg_valid = 1'b0;
        #3 rst = 1'b0;
        model_c = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle_busy", busy, 1'b0);
            check("post_rst_idle_c", c, '0);
        end

        // ---------------- parity word 3 ----------------
        for (int k = 0; k < NWORDS; k++) words[k] = CW'(k + 1);
        do_load(0, -1, -1);
        do_load(0, -1, 3);
        do_load(0, -1, -1);
        check("parity_recover_c", c, golden);

        // ---------------- randomized loads ----------------
        for (int it = 0; it < 24; it++) begin
            int ab;
            int fl;
            for (int k = 0; k < NWORDS; k++) words[k] = CW'($urandom_range(0, 255));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NWORDS - 1)) : -1;
            fl = (ab < 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, NWORDS - 1)) : -1;
            do_load(int'($urandom_range(0, 2)), ab, fl);
            check("rand_c", c, model_c);
            check("rand_err", err, model_err);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        step();
        step();
        check("exp_q_drained", exp_q.size(), 0);
        check("atomicity", n_atomic_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
